// File: rtl/tea_block_cipher.sv
// tea_block_cipher
//   Iterative TEA block cipher, one round per clock. Serves as the keystream
//   engine for the OFB mode wrapper: it takes the IV (or previous output block)
//   and the 128-bit key, and returns the 64-bit enciphered block.
//
//   Optional feature macro: TEA_DECRYPT_EN
//     When defined, adds the `decrypt` input and the inverse round datapath.
//     When undefined the core is encrypt-only.
//
// Parameters
//   ROUNDS     number of TEA rounds, legal range 1..64 (default 32)
//   DELTA      TEA round constant (default 32'h9E3779B9)
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous active-low reset
//   in_valid   block_in/key (and decrypt) are presented
//   in_ready   core idle and able to accept a block (registered)
//   block_in   input block, v0=[63:32], v1=[31:0]
//   key        k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0]
//   decrypt    (TEA_DECRYPT_EN only) run the inverse cipher, sampled at accept
//   out_valid  block_out holds a completed result (registered)
//   out_ready  consumer accepts block_out
//   block_out  result block, v0=[63:32], v1=[31:0] (registered, held)
//   busy       high while rounds are being computed (registered)

module tea_block_cipher #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  block_in,
   input  logic [127:0] key,
`ifdef TEA_DECRYPT_EN
   input  logic         decrypt,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  block_out,
   output logic         busy
);

   // Seven bits covers the full legal round range (up to 64).
   localparam int unsigned   CntW      = 7;
   localparam logic [CntW-1:0] LastRound = CntW'(ROUNDS - 1);

`ifdef TEA_DECRYPT_EN
   // Decryption starts from the final encryption sum, DELTA*ROUNDS mod 2^32.
   localparam logic [31:0] SumDecInit = 32'(DELTA * ROUNDS);
`endif

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // TEA mixing function shared by both halves of the round.
   function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                           input logic [31:0] ka,
                                           input logic [31:0] kb,
                                           input logic [31:0] s);
      tea_mix = ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
   endfunction

   state_e          state_q, state_d;
   logic [31:0]     v0_q, v0_d;
   logic [31:0]     v1_q, v1_d;
   logic [31:0]     sum_q, sum_d;
   logic [CntW-1:0] round_cnt_q, round_cnt_d;
   logic [127:0]    key_q, key_d;
   logic [63:0]     block_out_q, block_out_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
`ifdef TEA_DECRYPT_EN
   logic            decrypt_q, decrypt_d;
`endif

   logic [31:0] k0, k1, k2, k3;
   logic [31:0] v0_rnd, v1_rnd, sum_rnd;
   logic        accept;

   assign k0 = key_q[127:96];
   assign k1 = key_q[95:64];
   assign k2 = key_q[63:32];
   assign k3 = key_q[31:0];

   // in_ready is only raised one clock after reset release, so gating the
   // accept with it keeps the first post-reset edge from taking a block.
   assign accept = (state_q == StIdle) && in_ready_q && in_valid;

   // One full round of the datapath, computed from the current registers.
   always_comb begin
      sum_rnd = sum_q + DELTA;
      v0_rnd  = v0_q + tea_mix(v1_q, k0, k1, sum_rnd);
      // Second half deliberately uses the freshly updated v0.
      v1_rnd  = v1_q + tea_mix(v0_rnd, k2, k3, sum_rnd);
`ifdef TEA_DECRYPT_EN
      if (decrypt_q) begin
         // Inverse order: undo v1 first, then v0, both with the current sum.
         v1_rnd  = v1_q - tea_mix(v0_q, k2, k3, sum_q);
         v0_rnd  = v0_q - tea_mix(v1_rnd, k0, k1, sum_q);
         sum_rnd = sum_q - DELTA;
      end
`endif
   end

   // Next-state logic for the FSM and all datapath registers.
   always_comb begin
      state_d     = state_q;
      v0_d        = v0_q;
      v1_d        = v1_q;
      sum_d       = sum_q;
      round_cnt_d = round_cnt_q;
      key_d       = key_q;
      block_out_d = block_out_q;
`ifdef TEA_DECRYPT_EN
      decrypt_d   = decrypt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               v0_d        = block_in[63:32];
               v1_d        = block_in[31:0];
               key_d       = key;
               sum_d       = '0;
               round_cnt_d = '0;
`ifdef TEA_DECRYPT_EN
               decrypt_d   = decrypt;
               if (decrypt) begin
                  sum_d = SumDecInit;
               end
`endif
               state_d     = StRun;
            end
         end

         StRun: begin
            v0_d        = v0_rnd;
            v1_d        = v1_rnd;
            sum_d       = sum_rnd;
            round_cnt_d = round_cnt_q + 1'b1;
            if (round_cnt_q == LastRound) begin
               block_out_d = {v0_rnd, v1_rnd};
               state_d     = StDone;
            end
         end

         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Handshake/status outputs are registered views of the next state.
      in_ready_d  = (state_d == StIdle);
      out_valid_d = (state_d == StDone);
      busy_d      = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         v0_q        <= '0;
         v1_q        <= '0;
         sum_q       <= '0;
         round_cnt_q <= '0;
         key_q       <= '0;
         block_out_q <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef TEA_DECRYPT_EN
         decrypt_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         sum_q       <= sum_d;
         round_cnt_q <= round_cnt_d;
         key_q       <= key_d;
         block_out_q <= block_out_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef TEA_DECRYPT_EN
         decrypt_q   <= decrypt_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign block_out = block_out_q;

endmodule

// File: tb/tb_tea_block_cipher.sv
// tb_tea_block_cipher
//   Self-checking bench for tea_block_cipher. Expected blocks come from a
//   loop-based TEA reference model; stimulus mixes fixed vectors with
//   $urandom blocks and keys. Optional decrypt tests follow TEA_DECRYPT_EN.

module tb_tea_block_cipher;

   localparam int unsigned ROUNDS = 32;
   localparam logic [31:0] DELTA  = 32'h9E3779B9;
   localparam logic [63:0] KatZero = 64'h41EA3A0A94BAA940;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  block_in;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  block_out;
   logic         busy;
`ifdef TEA_DECRYPT_EN
   logic         decrypt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tea_block_cipher #(
      .ROUNDS (ROUNDS),
      .DELTA  (DELTA)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .block_in  (block_in),
      .key       (key),
`ifdef TEA_DECRYPT_EN
      .decrypt   (decrypt),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .block_out (block_out),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference TEA encipher, written as the classic C loop.
   function automatic logic [63:0] tea_enc(input logic [63:0] b, input logic [127:0] k);
      logic [31:0] y, z, s;
      y = b[63:32];
      z = b[31:0];
      s = 32'd0;
      for (int i = 0; i < ROUNDS; i++) begin
         s = s + DELTA;
         y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
         z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      end
      return {y, z};
   endfunction

   // Wait for in_ready, present one block, count edges to out_valid, check the
   // result, optionally stall the consumer, then complete the handshake.
   task automatic run_block(input string tag, input logic [63:0] blk, input logic [127:0] k,
                            input logic [63:0] exp, input bit scramble, input bit stall);
      int n;
      int edges;
      bit done;
      n = 0;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      block_in = blk;
      key      = k;
      in_valid = 1'b1;
      edges    = 0;
      done     = 1'b0;
      while (!done && edges < 200) begin
         @(negedge clk);
         edges++;
         in_valid = 1'b0;
         if (scramble) begin
            block_in = {$urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
         end
         if (edges == 2) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
         end
         if (out_valid) done = 1'b1;
      end
      // First counted edge is the accepting edge itself.
      check({tag, "_latency"}, 64'(edges - 1), 64'(ROUNDS));
      check({tag, "_result"}, block_out, exp);
      if (stall) begin
         for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            block_in = {$urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_stall_hold"}, block_out, exp);
            check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
      check({tag, "_retain"}, block_out, exp);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

`ifdef TEA_DECRYPT_EN
   function automatic logic [63:0] tea_dec(input logic [63:0] b, input logic [127:0] k);
      logic [31:0] y, z, s;
      y = b[63:32];
      z = b[31:0];
      s = 32'(DELTA * ROUNDS);
      for (int i = 0; i < ROUNDS; i++) begin
         z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
         y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
         s = s - DELTA;
      end
      return {y, z};
   endfunction
`endif

   initial begin
      logic [63:0]  blk;
      logic [63:0]  exp;
      logic [127:0] k;

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      block_in  = '0;
      key       = '0;
`ifdef TEA_DECRYPT_EN
      decrypt   = 1'b0;
`endif

      // Reset values while reset is held.
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_block_out", block_out, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_release_in_ready", 64'(in_ready), 64'd1);

      // Known answer, plus model agreement with the zero vector.
      check("model_kat", tea_enc(64'd0, 128'd0), KatZero);
      run_block("kat", 64'd0, 128'd0, KatZero, 1'b0, 1'b0);

      // OFB-style chaining with the fixed key.
      k   = 128'h0123456789abcdef0123456789abcdef;
      blk = 64'h0123456789abcdef;
      for (int i = 0; i < 4; i++) begin
         exp = tea_enc(blk, k);
         run_block("ofb", blk, k, exp, 1'b0, 1'b0);
         blk = exp;
      end

      // Random blocks and keys.
      for (int i = 0; i < 6; i++) begin
         blk = {$urandom, $urandom};
         k   = {$urandom, $urandom, $urandom, $urandom};
         run_block("rand", blk, k, tea_enc(blk, k), 1'b0, 1'b0);
      end

      // Inputs change every cycle once accepted.
      run_block("volatile", 64'd0, 128'd0, KatZero, 1'b1, 1'b0);

      // Output backpressure with an ignored in_valid.
      blk = {$urandom, $urandom};
      k   = {$urandom, $urandom, $urandom, $urandom};
      run_block("stall", blk, k, tea_enc(blk, k), 1'b0, 1'b1);

      // Abort mid-operation; block_out is nonzero before the reset.
      block_in = 64'h0123456789abcdef;
      key      = 128'h0123456789abcdef0123456789abcdef;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_block_out", block_out, 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_release_in_ready", 64'(in_ready), 64'd1);
      run_block("post_abort", 64'd0, 128'd0, KatZero, 1'b0, 1'b0);

`ifdef TEA_DECRYPT_EN
      decrypt = 1'b1;
      run_block("dec_kat", KatZero, 128'd0, 64'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         blk = {$urandom, $urandom};
         k   = {$urandom, $urandom, $urandom, $urandom};
         exp = tea_enc(blk, k);
         check("model_roundtrip", tea_dec(exp, k), blk);
         decrypt = 1'b0;
         run_block("rt_enc", blk, k, exp, 1'b0, 1'b0);
         decrypt = 1'b1;
         run_block("rt_dec", exp, k, blk, 1'b0, 1'b0);
      end
      decrypt = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tea_block_cipher.md
Name: tea_block_cipher

Overview:
Iterative TEA (Tiny Encryption Algorithm) block-cipher core, one round per clock. It is the keystream engine sitting directly upstream of the OFB mode wrapper. The OFB wrapper feeds it the IV or the previous output block, plus the 128-bit key, and consumes the 64-bit enciphered block as keystream. It uses a valid/ready handshake on both input and output so the wrapper can stall it.

Parameters:
ROUNDS, 32, number of TEA rounds; legal range 1..64.
DELTA, 32'h9E3779B9, TEA round constant.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  block and key presented on block_in/key
in_ready  output  1  core idle and able to accept a block
block_in  input  64  plaintext block; v0=[63:32], v1=[31:0]
key  input  128  k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0]
out_valid  output  1  block_out holds a completed result
out_ready  input  1  consumer accepts block_out
block_out  output  64  cipher block; v0=[63:32], v1=[31:0]
busy  output  1  high while in the RUN state

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready=0 while reset is asserted, then 1 from the first clk after release; out_valid=0; busy=0; block_out=0; internal v0/v1/sum/round counter/key registers=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch v0, v1 and k0..k3, set sum=0, set round_cnt=0, go to RUN.
  - Inputs are not sampled afterwards, so key and block_in may change freely once accepted.
- RUN:
  - in_ready=0, busy=1.
  - Each edge performs one round, all arithmetic mod 2^32, shifts logical:
    - sum' = sum + DELTA
    - v0' = v0 + (((v1<<4)+k0) ^ (v1+sum') ^ ((v1>>5)+k1))
    - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+sum') ^ ((v0'>>5)+k3))
  - v1' uses the updated v0' within the same cycle.
  - round_cnt increments each edge. On the edge completing round ROUNDS: load block_out={v0',v1'}, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly ROUNDS rising edges after the accepting edge (32 for the default).
- DONE:
  - out_valid=1; block_out held stable; in_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - There is no same-cycle re-accept, so maximum throughput is one block per ROUNDS+2 cycles.
- out_ready outside DONE and in_valid outside IDLE are ignored.
- block_out retains the last result after the handshake until overwritten by the next completion.
- Reset asserted mid-RUN or in DONE: the operation is aborted and the result discarded; all outputs return to reset values; no partial result is ever presented.

Optional Feature:
Macro TEA_DECRYPT_EN.
- Defined:
  - Adds input port decrypt (1 bit), sampled with block_in on the accepting edge.
  - decrypt=1 initialises sum to DELTA*ROUNDS (mod 2^32; 32'hC6EF3720 for 32 rounds).
  - Each round then computes, in this order:
    - v1' = v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3))
    - v0' = v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1))
    - sum' = sum - DELTA
  - Latency and handshake are identical to encryption.
- Not defined: no decrypt port; the core is encrypt-only (OFB needs only the forward cipher).

Test Plan:
- Known answer: key=0, block_in=0, in_valid for one cycle -> out_valid exactly 32 edges later, block_out=64'h41EA3A0A94BAA940.
- Model check: key=128'h0123456789abcdef0123456789abcdef, block_in=64'h0123456789abcdef -> block_out equals the C reference TEA model; feeding the result back as the next block_in (OFB chaining) for 4 blocks matches the model each time.
- Backpressure: hold out_ready=0 for 20 cycles after completion -> out_valid stays 1, block_out stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> out_valid falls, in_ready=1 next cycle.
- Input volatility: change key and block_in every cycle during RUN -> result equals the known-answer value for the originally accepted inputs.
- Reset mid-operation: pull reset low at round 15 -> out_valid=0 and block_out=0 immediately (asynchronously); after release, a fresh known-answer transaction completes correctly in 32 edges.
- With TEA_DECRYPT_EN: decrypt=1, key=0, block_in=64'h41EA3A0A94BAA940 -> block_out=0 after 32 edges; encrypt-then-decrypt round trip of random blocks returns the original plaintext.
